rvfi_retire_serializer: RTL and testbench

- Sits directly upstream of the single-channel PC and order checkers.
- Collapses a multi-channel RVFI retirement bus (up to NRET retirements per cycle) into one in-order retirement per cycle, buffered in a FIFO.
- Lets single-channel checkers observe every retirement with consecutive rvfi_order values on one stream.
- Flags buffer overflow and non-consecutive order as sticky errors for the formal harness to assert on.

---
 rtl/rvfi_retire_serializer.sv | 177 +++++++++++++++++
 tb/tb_rvfi_retire_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_serializer.sv
// rvfi_retire_serializer: collapses NRET RVFI retirement channels into one
// in-order retirement per cycle, buffered in a DEPTH-entry FIFO.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   in_valid            per-channel retirement valid (NRET bits)
//   in_order            per-channel rvfi_order, channel i at [64*i +: 64]
//   in_pc_rdata/wdata   per-channel PC and next PC, channel i at [XLEN*i +: XLEN]
//   in_rollback         flush: empties FIFO, drops same-cycle arrivals
//   out_valid           serialized retirement valid
//   out_order           order of the serialized retirement
//   out_pc_rdata/wdata  PC / next PC of the serialized retirement
//   level               FIFO occupancy, not counting the output register
//   overflow            sticky: a retirement was dropped on a full FIFO
//   order_err           sticky: a non-consecutive order was accepted
//
// Optional: define RISCV_FORMAL_SERIAL_ORDER_CHECK_EN to build the
// expected-order tracker; otherwise order_err is tied to 0.
module rvfi_retire_serializer #(
    parameter int XLEN  = 32,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NRET-1:0]          in_valid,
    input  logic [64*NRET-1:0]       in_order,
    input  logic [XLEN*NRET-1:0]     in_pc_rdata,
    input  logic [XLEN*NRET-1:0]     in_pc_wdata,
    input  logic                     in_rollback,
    output logic                     out_valid,
    output logic [63:0]              out_order,
    output logic [XLEN-1:0]          out_pc_rdata,
    output logic [XLEN-1:0]          out_pc_wdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     order_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [63:0]     mem_order [DEPTH];
    logic [XLEN-1:0] mem_rdata [DEPTH];
    logic [XLEN-1:0] mem_wdata [DEPTH];

    logic [PW-1:0] head_q, tail_q;

    // Compacted arrivals: slot k holds the k-th valid channel.
    logic [63:0]     a_order [NRET];
    logic [XLEN-1:0] a_rdata [NRET];
    logic [XLEN-1:0] a_wdata [NRET];
    logic [NRET-1:0] wr_en;
    logic [PW-1:0]   wr_addr [NRET];

    int   narr, room, nacc;
    logic pop, bypass, ovf_hit;
    logic [LW-1:0] level_n;
    logic [PW-1:0] head_n, tail_n;

    always_comb begin
        narr = 0;
        for (int k = 0; k < NRET; k++) begin
            a_order[k] = '0;
            a_rdata[k] = '0;
            a_wdata[k] = '0;
        end
        for (int i = 0; i < NRET; i++) begin
            for (int k = 0; k < NRET; k++) begin
                if (in_valid[i] && narr == k) begin
                    a_order[k] = in_order[64*i +: 64];
                    a_rdata[k] = in_pc_rdata[XLEN*i +: XLEN];
                    a_wdata[k] = in_pc_wdata[XLEN*i +: XLEN];
                end
            end
            if (in_valid[i]) narr = narr + 1;
        end

        pop    = (level != '0) || (narr != 0);
        bypass = (level == '0) && (narr != 0);
        // Slots available this cycle: free entries plus the one being popped.
        room    = DEPTH - int'(level) + (pop ? 1 : 0);
        nacc    = (narr < room) ? narr : room;
        ovf_hit = narr > room;

        // The bypassed arrival goes straight to the output, not the FIFO.
        for (int k = 0; k < NRET; k++) begin
            wr_en[k]   = (k < nacc) && !(bypass && k == 0) && !in_rollback;
            wr_addr[k] = PW'(int'(tail_q) + k - (bypass ? 1 : 0));
        end

        level_n = LW'(int'(level) + nacc - (pop ? 1 : 0));
        head_n  = PW'(int'(head_q) + ((level != '0) ? 1 : 0));
        tail_n  = PW'(int'(tail_q) + nacc - (bypass ? 1 : 0));
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < NRET; k++) begin
            if (wr_en[k]) begin
                mem_order[wr_addr[k]] <= a_order[k];
                mem_rdata[wr_addr[k]] <= a_rdata[k];
                mem_wdata[wr_addr[k]] <= a_wdata[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_order    <= '0;
            out_pc_rdata <= '0;
            out_pc_wdata <= '0;
            level        <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            overflow     <= 1'b0;
        end else if (in_rollback) begin
            out_valid <= 1'b0;
            level     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
        end else begin
            out_valid <= pop;
            level     <= level_n;
            head_q    <= head_n;
            tail_q    <= tail_n;
            overflow  <= overflow | ovf_hit;
            if (pop) begin
                if (level != '0) begin
                    out_order    <= mem_order[head_q];
                    out_pc_rdata <= mem_rdata[head_q];
                    out_pc_wdata <= mem_wdata[head_q];
                end else begin
                    out_order    <= a_order[0];
                    out_pc_rdata <= a_rdata[0];
                    out_pc_wdata <= a_wdata[0];
                end
            end
        end
    end

`ifdef RISCV_FORMAL_SERIAL_ORDER_CHECK_EN
    logic [63:0] exp_q, exp_v;
    logic        armed_q, arm_v, err_v;

    // Walk accepted arrivals oldest first; dropped ones never touch exp.
    always_comb begin
        exp_v = exp_q;
        arm_v = armed_q;
        err_v = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (k < nacc) begin
                if (arm_v && a_order[k] != exp_v) err_v = 1'b1;
                exp_v = a_order[k] + 64'd1;
                arm_v = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exp_q     <= '0;
            armed_q   <= 1'b0;
            order_err <= 1'b0;
        end else if (in_rollback) begin
            armed_q <= 1'b0;
        end else begin
            exp_q     <= exp_v;
            armed_q   <= arm_v;
            order_err <= order_err | err_v;
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// Directed self-checking bench for rvfi_retire_serializer
// (XLEN=32, NRET=2, DEPTH=8).
module tb_rvfi_retire_serializer;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  in_valid;
    logic [127:0] in_order;
    logic [63:0] in_pc_rdata;
    logic [63:0] in_pc_wdata;
    logic        in_rollback;
    logic        out_valid;
    logic [63:0] out_order;
    logic [31:0] out_pc_rdata;
    logic [31:0] out_pc_wdata;
    logic [3:0]  level;
    logic        overflow;
    logic        order_err;

    int n_cmp = 0;
    int n_bad = 0;

    rvfi_retire_serializer #(.XLEN(32), .NRET(2), .DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_order     (in_order),
        .in_pc_rdata  (in_pc_rdata),
        .in_pc_wdata  (in_pc_wdata),
        .in_rollback  (in_rollback),
        .out_valid    (out_valid),
        .out_order    (out_order),
        .out_pc_rdata (out_pc_rdata),
        .out_pc_wdata (out_pc_wdata),
        .level        (level),
        .overflow     (overflow),
        .order_err    (order_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pc_of(input logic [63:0] o);
        logic [63:0] t;
        t = 64'h1000 + o * 4;
        return t[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] o0,
                         input logic [63:0] o1);
        in_valid    = v;
        in_order    = {o1, o0};
        in_pc_rdata = {pc_of(o1), pc_of(o0)};
        in_pc_wdata = {pc_of(o1) + 32'd4, pc_of(o0) + 32'd4};
    endtask

    task automatic idle();
        drive(2'b00, 64'd0, 64'd0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        in_rollback = 1'b0;
        idle();
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_order", out_order, 64'd0);
        chk("rst_pc", 64'(out_pc_rdata), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_oerr", 64'(order_err), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single channel, 1-cycle latency
        in_valid    = 2'b01;
        in_order    = {64'd0, 64'd5};
        in_pc_rdata = {32'd0, 32'h100};
        in_pc_wdata = {32'd0, 32'h104};
        step();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_order", out_order, 64'd5);
        chk("single_rdata", 64'(out_pc_rdata), 64'h100);
        chk("single_wdata", 64'(out_pc_wdata), 64'h104);
        chk("single_level", 64'(level), 64'd0);
        idle();
        step();
        chk("single_idle", 64'(out_valid), 64'd0);
        chk("single_hold", out_order, 64'd5);

        // Dual retire: orders 10..15 over 3 cycles
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) drive(2'b11, 64'(10 + 2*c), 64'(11 + 2*c));
            else idle();
            step();
            chk("dual_valid", 64'(out_valid), 64'd1);
            chk("dual_order", out_order, 64'(10 + c));
            chk("dual_rdata", 64'(out_pc_rdata), 64'(pc_of(64'(10 + c))));
            chk("dual_level", 64'(level), 64'(c < 3 ? c + 1 : 5 - c));
        end
        step();
        chk("dual_end_valid", 64'(out_valid), 64'd0);
        chk("dual_oerr", 64'(order_err), 64'd0);
        chk("dual_ovf", 64'(overflow), 64'd0);

        // Fill to DEPTH, then full+pop with one arrival, then overflow
        pulse_reset();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 64'(2*c), 64'(2*c + 1));
            step();
            chk("fill_order", out_order, 64'(c));
            chk("fill_level", 64'(level), 64'(c + 1));
        end
        chk("fill_ovf", 64'(overflow), 64'd0);
        drive(2'b01, 64'd16, 64'd0);
        step();
        chk("full1_order", out_order, 64'd8);
        chk("full1_level", 64'(level), 64'd8);
        chk("full1_ovf", 64'(overflow), 64'd0);
        drive(2'b11, 64'd17, 64'd18);
        step();
        chk("ovf_order", out_order, 64'd9);
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_set", 64'(overflow), 64'd1);
        idle();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("drain_order", out_order, 64'(10 + c));
            chk("drain_level", 64'(level), 64'(7 - c));
            chk("drain_ovf", 64'(overflow), 64'd1);
        end
        chk("drain_oerr", 64'(order_err), 64'd0);

        // Async reset between edges with level=5, overflow=1
        #2;
        reset = 1'b1;
        #1;
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_level", 64'(level), 64'd0);
        chk("areset_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;

        // Gap / compaction, then order jump
        drive(2'b01, 64'd6, 64'd0);
        step();
        chk("gap_first", out_order, 64'd6);
        drive(2'b10, 64'd99, 64'd7);
        step();
        chk("gap_valid", 64'(out_valid), 64'd1);
        chk("gap_order", out_order, 64'd7);
        chk("gap_rdata", 64'(out_pc_rdata), 64'(pc_of(64'd7)));
        chk("gap_oerr", 64'(order_err), 64'd0);
        drive(2'b01, 64'd9, 64'd0);
        step();
        chk("jump_order", out_order, 64'd9);
`ifdef RISCV_FORMAL_SERIAL_ORDER_CHECK_EN
        chk("jump_oerr", 64'(order_err), 64'd1);
`else
        chk("jump_oerr", 64'(order_err), 64'd0);
`endif
        idle();
        step();
        chk("jump_idle", 64'(out_valid), 64'd0);

        // Rollback at level=4 with same-cycle arrivals
        pulse_reset();
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 64'(2*c), 64'(2*c + 1));
            step();
        end
        chk("rb_pre_level", 64'(level), 64'd4);
        chk("rb_pre_order", out_order, 64'd3);
        drive(2'b11, 64'd50, 64'd51);
        in_rollback = 1'b1;
        step();
        in_rollback = 1'b0;
        idle();
        chk("rb_valid", 64'(out_valid), 64'd0);
        chk("rb_level", 64'(level), 64'd0);
        step();
        chk("rb_after_valid", 64'(out_valid), 64'd0);
        chk("rb_after_level", 64'(level), 64'd0);
        drive(2'b01, 64'd100, 64'd0);
        step();
        chk("rb_new_valid", 64'(out_valid), 64'd1);
        chk("rb_new_order", out_order, 64'd100);
        chk("rb_new_oerr", 64'(order_err), 64'd0);
        idle();
        step();
        chk("rb_end_valid", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
